// File: rtl/button_debounce.sv
// button_debounce: synchroniser, bounce filter and auto-repeat for the MIC-1
// front-panel buttons; feeds button_fsm with clean press/release pulses.
//
// Ports:
//   clk            system clock, sole clock domain
//   reset          synchronous, active-high reset
//   button_raw     raw asynchronous pushbuttons, active-high
//   button_level   debounced level per channel
//   button_press   one-cycle pulse on debounced rise and on each auto-repeat
//   button_release one-cycle pulse on debounced fall
module button_debounce #(
    parameter int                   N_BUTTONS       = 4,
    parameter int                   DEBOUNCE_CYCLES = 8,
    parameter logic [N_BUTTONS-1:0] REPEAT_MASK     = N_BUTTONS'(4'b0100),
    parameter int                   REPEAT_DELAY    = 32,
    parameter int                   REPEAT_PERIOD   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] button_raw,
    output logic [N_BUTTONS-1:0] button_level,
    output logic [N_BUTTONS-1:0] button_press,
    output logic [N_BUTTONS-1:0] button_release
);

    localparam int DW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                         : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rpt_state_t;

    // Two-flop synchroniser; only r_s2 is ever looked at by the filter.
    logic [N_BUTTONS-1:0] r_s1;
    logic [N_BUTTONS-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= button_raw;
            r_s2 <= r_s1;
        end
    end

    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_ch
        logic [DW-1:0] r_db_cnt;
        logic [RW-1:0] r_rp_cnt;
        rpt_state_t    r_state;
        logic          r_level;
        logic          r_press;
        logic          r_release;
        logic          w_diff;
        logic          w_commit;

        assign w_diff   = r_s2[gi] != r_level;
        assign w_commit = w_diff && (r_db_cnt == DB_LAST);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_db_cnt  <= '0;
                r_rp_cnt  <= '0;
                r_state   <= ST_IDLE;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;

                // Stability filter: any sample agreeing with the level
                // restarts the count, so short excursions never commit.
                if (!w_diff) begin
                    r_db_cnt <= '0;
                end else if (w_commit) begin
                    r_db_cnt  <= '0;
                    r_level   <= r_s2[gi];
                    r_press   <= r_s2[gi];
                    r_release <= !r_s2[gi];
                end else begin
                    r_db_cnt <= r_db_cnt + DW'(1);
                end

                // Auto-repeat. A falling commit always wins, so a repeat
                // that would land on the release edge is dropped.
                if (!REPEAT_MASK[gi]) begin
                    r_state  <= ST_IDLE;
                    r_rp_cnt <= '0;
                end else if (w_commit && !r_s2[gi]) begin
                    r_state  <= ST_IDLE;
                    r_rp_cnt <= '0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            r_rp_cnt <= '0;
                            if (w_commit) begin
                                r_state <= ST_DELAY;
                            end
                        end
                        ST_DELAY: begin
                            if (r_rp_cnt == RD_LAST) begin
                                r_press  <= 1'b1;
                                r_rp_cnt <= '0;
                                r_state  <= ST_REPEAT;
                            end else begin
                                r_rp_cnt <= r_rp_cnt + RW'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (r_rp_cnt == RP_LAST) begin
                                r_press  <= 1'b1;
                                r_rp_cnt <= '0;
                            end else begin
                                r_rp_cnt <= r_rp_cnt + RW'(1);
                            end
                        end
                        default: begin
                            r_state  <= ST_IDLE;
                            r_rp_cnt <= '0;
                        end
                    endcase
                end
            end
        end

        assign button_level[gi]   = r_level;
        assign button_press[gi]   = r_press;
        assign button_release[gi] = r_release;
    end

endmodule
